// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station: oldest-first issue with CDB wake-up.
// Optional macro RS_WAKEUP_BYPASS_EN lets a CDB broadcast make an entry issue in the same cycle.
module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [3:0]             disp_alu_ctl,
  input  logic [31:0]            disp_op1,
  input  logic [31:0]            disp_op2,
  input  logic                   disp_op1_rdy,
  input  logic                   disp_op2_rdy,
  input  logic [TAG_W-1:0]       disp_op1_tag,
  input  logic [TAG_W-1:0]       disp_op2_tag,
  input  logic [TAG_W-1:0]       disp_tag,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [31:0]            cdb_value,
  input  logic                   alu_ready,
  output logic                   out_valid,
  output logic [3:0]             out_alu_ctl,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [3:0] ALUCTL_NOP = 4'd0;

  logic [DEPTH-1:0] busy_q, rdy1_q, rdy2_q;
  logic [3:0]       ctl_q  [DEPTH];
  logic [31:0]      op1_q  [DEPTH];
  logic [31:0]      op2_q  [DEPTH];
  logic [TAG_W-1:0] tag1_q [DEPTH];
  logic [TAG_W-1:0] tag2_q [DEPTH];
  logic [TAG_W-1:0] dtag_q [DEPTH];
  // age = number of older entries still resident, so the oldest has age 0
  logic [IW-1:0]    age_q  [DEPTH];

  logic [DEPTH-1:0] m1, m2, elig;
  logic             free_found, sel_found;
  logic [IW-1:0]    free_idx, sel_idx, sel_age, age_new;
  logic             disp_fire, issue_fire;
  logic             d_cap1, d_cap2;
  logic [CW-1:0]    count_next;

  always_comb begin
    m1   = '0;
    m2   = '0;
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m1[i] = cdb_valid && busy_q[i] && !rdy1_q[i] && (tag1_q[i] == cdb_tag);
      m2[i] = cdb_valid && busy_q[i] && !rdy2_q[i] && (tag2_q[i] == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
      elig[i] = busy_q[i] && (rdy1_q[i] || m1[i]) && (rdy2_q[i] || m2[i]);
`else
      elig[i] = busy_q[i] && rdy1_q[i] && rdy2_q[i];
`endif
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_age    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (elig[i] && (!sel_found || (age_q[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_age   = age_q[i];
      end
    end
  end

  // A slot freed by this cycle's issue is not offered to dispatch until next cycle
  assign disp_ready = !rst && !flush && (count < CW'(DEPTH)) && free_found;
  assign disp_fire  = disp_valid && disp_ready;
  assign out_valid  = sel_found && alu_ready && !flush && !rst;
  assign issue_fire = out_valid;

  assign d_cap1  = !disp_op1_rdy && cdb_valid && (disp_op1_tag == cdb_tag);
  assign d_cap2  = !disp_op2_rdy && cdb_valid && (disp_op2_tag == cdb_tag);
  assign age_new = IW'(count - CW'(issue_fire));

  always_comb begin
    out_alu_ctl = ALUCTL_NOP;
    out_op1     = '0;
    out_op2     = '0;
    out_tag     = '0;
    if (out_valid) begin
      out_alu_ctl = ctl_q[sel_idx];
      out_tag     = dtag_q[sel_idx];
`ifdef RS_WAKEUP_BYPASS_EN
      out_op1     = m1[sel_idx] ? cdb_value : op1_q[sel_idx];
      out_op2     = m2[sel_idx] ? cdb_value : op2_q[sel_idx];
`else
      out_op1     = op1_q[sel_idx];
      out_op2     = op2_q[sel_idx];
`endif
    end
  end

  always_comb begin
    count_next = count;
    if (disp_fire && !issue_fire)
      count_next = count + 1'b1;
    else if (!disp_fire && issue_fire)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      busy_q <= '0;
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i]) begin
          if (m1[i]) begin
            rdy1_q[i] <= 1'b1;
            op1_q[i]  <= cdb_value;
          end
          if (m2[i]) begin
            rdy2_q[i] <= 1'b1;
            op2_q[i]  <= cdb_value;
          end
          if (issue_fire && (sel_idx == IW'(i)))
            busy_q[i] <= 1'b0;
          else if (issue_fire && (age_q[i] > sel_age))
            age_q[i] <= age_q[i] - 1'b1;
        end
      end
      if (disp_fire) begin
        busy_q[free_idx] <= 1'b1;
        ctl_q[free_idx]  <= disp_alu_ctl;
        dtag_q[free_idx] <= disp_tag;
        tag1_q[free_idx] <= disp_op1_tag;
        tag2_q[free_idx] <= disp_op2_tag;
        rdy1_q[free_idx] <= disp_op1_rdy || d_cap1;
        rdy2_q[free_idx] <= disp_op2_rdy || d_cap2;
        op1_q[free_idx]  <= d_cap1 ? cdb_value : disp_op1;
        op2_q[free_idx]  <= d_cap2 ? cdb_value : disp_op2;
        age_q[free_idx]  <= age_new;
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed and randomized checks of alu_reservation_station.
module tb_alu_reservation_station;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, disp_valid, disp_ready, disp_op1_rdy, disp_op2_rdy;
  logic [3:0] disp_alu_ctl, out_alu_ctl;
  logic [31:0] disp_op1, disp_op2, cdb_value, out_op1, out_op2;
  logic [TAG_W-1:0] disp_op1_tag, disp_op2_tag, disp_tag, cdb_tag, out_tag;
  logic cdb_valid, alu_ready, out_valid;
  logic [$clog2(DEPTH):0] count;

  alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_alu_ctl(disp_alu_ctl), .disp_op1(disp_op1), .disp_op2(disp_op2),
    .disp_op1_rdy(disp_op1_rdy), .disp_op2_rdy(disp_op2_rdy),
    .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .alu_ready(alu_ready),
    .out_valid(out_valid), .out_alu_ctl(out_alu_ctl), .out_op1(out_op1), .out_op2(out_op2),
    .out_tag(out_tag), .count(count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: instructions in dispatch order, oldest at the front
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] v1, v2;
    bit          r1, r2;
    logic [3:0]  t1, t2, dt;
  } ent_t;
  ent_t mq[$];

  bit          exp_valid, exp_ready;
  int          exp_sel, exp_count;
  logic [3:0]  exp_ctl, exp_tag;
  logic [31:0] exp_op1, exp_op2;

  function automatic bit hit(bit r, logic [3:0] t);
    return !r && cdb_valid && (t == cdb_tag);
  endfunction

  task automatic predict();
    #1;
    exp_count = mq.size();
    exp_ready = !rst && !flush && (mq.size() < DEPTH);
    exp_sel   = -1;
    foreach (mq[k]) begin
      if (exp_sel < 0) begin
`ifdef RS_WAKEUP_BYPASS_EN
        if ((mq[k].r1 || hit(mq[k].r1, mq[k].t1)) && (mq[k].r2 || hit(mq[k].r2, mq[k].t2))) exp_sel = k;
`else
        if (mq[k].r1 && mq[k].r2) exp_sel = k;
`endif
      end
    end
    exp_valid = (exp_sel >= 0) && alu_ready && !flush && !rst;
    exp_ctl = 4'd0; exp_op1 = '0; exp_op2 = '0; exp_tag = '0;
    if (exp_valid) begin
      exp_ctl = mq[exp_sel].ctl;
      exp_tag = mq[exp_sel].dt;
      exp_op1 = mq[exp_sel].r1 ? mq[exp_sel].v1 : cdb_value;
      exp_op2 = mq[exp_sel].r2 ? mq[exp_sel].v2 : cdb_value;
    end
  endtask

  task automatic tick();
    ent_t e;
    predict();
    @(posedge clk);
    if (rst || flush) mq.delete();
    else begin
      if (exp_valid) mq.delete(exp_sel);
      foreach (mq[k]) begin
        if (hit(mq[k].r1, mq[k].t1)) begin mq[k].r1 = 1'b1; mq[k].v1 = cdb_value; end
        if (hit(mq[k].r2, mq[k].t2)) begin mq[k].r2 = 1'b1; mq[k].v2 = cdb_value; end
      end
      if (disp_valid && exp_ready) begin
        e.ctl = disp_alu_ctl; e.dt = disp_tag; e.t1 = disp_op1_tag; e.t2 = disp_op2_tag;
        e.r1 = disp_op1_rdy || hit(1'b0, disp_op1_tag) && !disp_op1_rdy;
        e.r2 = disp_op2_rdy || hit(1'b0, disp_op2_tag) && !disp_op2_rdy;
        e.v1 = disp_op1_rdy ? disp_op1 : cdb_value;
        e.v2 = disp_op2_rdy ? disp_op2 : cdb_value;
        mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic disp(input logic [3:0] ctl, input logic [31:0] o1, input bit r1, input logic [3:0] t1,
                      input logic [31:0] o2, input bit r2, input logic [3:0] t2, input logic [3:0] dt);
    disp_valid = 1; disp_alu_ctl = ctl; disp_op1 = o1; disp_op1_rdy = r1; disp_op1_tag = t1;
    disp_op2 = o2; disp_op2_rdy = r2; disp_op2_tag = t2; disp_tag = dt;
  endtask

  task automatic test_reset();
    rst = 1; alu_ready = 1; idle();
    disp(4'd1, 32'd1, 1, 4'd0, 32'd2, 1, 4'd0, 4'd1);
    predict();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL reset_disp_ready got=%b exp=0", disp_ready); end
    tick(); tick();
    rst = 0; idle();
    predict();
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", disp_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_basic();
    alu_ready = 1;
    disp(4'd1, 32'd5, 1, 4'd0, 32'd7, 1, 4'd0, 4'd3);
    tick(); idle(); predict();
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'd5 || out_op2 !== 32'd7 || out_tag !== 4'd3 || out_alu_ctl !== 4'd1)
      begin errors++; $display("FAIL basic_issue got v=%b op1=%0d op2=%0d tag=%0d ctl=%0d exp v=1 5 7 3 1", out_valid, out_op1, out_op2, out_tag, out_alu_ctl); end
    checks++; if (count !== 1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    tick(); predict();
    checks++; if (count !== 0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0 || out_op1 !== 0 || out_tag !== 0 || out_alu_ctl !== 4'd0)
      begin errors++; $display("FAIL basic_idle_zero got v=%b op1=%0d tag=%0d ctl=%0d exp all 0", out_valid, out_op1, out_tag, out_alu_ctl); end
  endtask

  task automatic test_wakeup();
    alu_ready = 1;
    disp(4'd2, 32'd0, 0, 4'd2, 32'd1, 1, 4'd0, 4'd4);
    tick(); idle(); tick();
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h10;
    predict();
`ifdef RS_WAKEUP_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h10 || out_tag !== 4'd4)
      begin errors++; $display("FAIL wakeup_bypass got v=%b op1=%h tag=%0d exp 1 10 4", out_valid, out_op1, out_tag); end
    tick(); idle();
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wakeup_early got=%b exp=0", out_valid); end
    tick(); idle(); predict();
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'h10 || out_tag !== 4'd4)
      begin errors++; $display("FAIL wakeup_issue got v=%b op1=%h tag=%0d exp 1 10 4", out_valid, out_op1, out_tag); end
    tick();
`endif
    predict();
    checks++; if (count !== 0) begin errors++; $display("FAIL wakeup_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    alu_ready = 0;
    for (int t = 1; t <= 4; t++) begin
      disp(4'd3, 32'(t * 10), 1, 4'd0, 32'(t), 1, 4'd0, 4'(t));
      tick();
    end
    idle(); predict();
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b exp=0", disp_ready); end
    checks++; if (count !== 4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    alu_ready = 1;
    for (int t = 1; t <= 4; t++) begin
      predict();
      checks++; if (out_valid !== 1'b1 || out_tag !== 4'(t) || count !== 3'(5 - t))
        begin errors++; $display("FAIL fill_order got v=%b tag=%0d cnt=%0d exp 1 %0d %0d", out_valid, out_tag, count, t, 5 - t); end
      tick();
    end
  endtask

  task automatic test_age();
    alu_ready = 0;
    disp(4'd1, 32'd0, 0, 4'd9, 32'd1, 1, 4'd0, 4'd1); tick();
    disp(4'd1, 32'd2, 1, 4'd0, 32'd2, 1, 4'd0, 4'd2); tick();
    alu_ready = 1;
    disp(4'd1, 32'd3, 1, 4'd0, 32'd3, 1, 4'd0, 4'd3); predict();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd2) begin errors++; $display("FAIL age_younger got v=%b tag=%0d exp 1 2", out_valid, out_tag); end
    tick(); idle();
    alu_ready = 0; cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 32'h99; tick();
    idle(); alu_ready = 1; predict();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd1 || out_op1 !== 32'h99)
      begin errors++; $display("FAIL age_older got v=%b tag=%0d op1=%h exp 1 1 99", out_valid, out_tag, out_op1); end
    tick(); predict();
    checks++; if (out_valid !== 1'b1 || out_tag !== 4'd3) begin errors++; $display("FAIL age_last got v=%b tag=%0d exp 1 3", out_valid, out_tag); end
    tick();
  endtask

  task automatic test_flush();
    alu_ready = 0;
    for (int t = 5; t <= 7; t++) begin disp(4'd1, 32'(t), 1, 4'd0, 32'(t), 1, 4'd0, 4'(t)); tick(); end
    flush = 1; alu_ready = 1;
    disp(4'd1, 32'd8, 1, 4'd0, 32'd8, 1, 4'd0, 4'd8); predict();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", disp_ready); end
    tick(); idle(); predict();
    checks++; if (count !== 0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    for (int c = 0; c < 3; c++) begin
      predict();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got v=%b tag=%0d exp v=0", out_valid, out_tag); end
      tick();
    end
  endtask

  task automatic test_capture();
    alu_ready = 1;
    disp(4'd4, 32'd1, 1, 4'd0, 32'd0, 0, 4'd5, 4'd10);
    cdb_valid = 1; cdb_tag = 4'd5; cdb_value = 32'hFF;
    tick(); idle(); predict();
    checks++; if (out_valid !== 1'b1 || out_op2 !== 32'hFF || out_tag !== 4'd10)
      begin errors++; $display("FAIL capture got v=%b op2=%h tag=%0d exp 1 ff 10", out_valid, out_op2, out_tag); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      alu_ready = ($urandom_range(0, 3) != 0);
      disp_valid = $urandom_range(0, 1);
      disp_alu_ctl = 4'($urandom); disp_tag = 4'($urandom);
      disp_op1 = $urandom; disp_op2 = $urandom;
      disp_op1_rdy = $urandom_range(0, 1); disp_op2_rdy = $urandom_range(0, 1);
      disp_op1_tag = 4'($urandom_range(0, 7)); disp_op2_tag = 4'($urandom_range(0, 7));
      cdb_valid = $urandom_range(0, 1); cdb_tag = 4'($urandom_range(0, 7)); cdb_value = $urandom;
      predict();
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_valid); end
      checks++; if ({out_alu_ctl, out_op1, out_op2, out_tag} !== {exp_ctl, exp_op1, exp_op2, exp_tag})
        begin errors++; $display("FAIL rand_fields cyc=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c, out_alu_ctl, out_op1, out_op2, out_tag, exp_ctl, exp_op1, exp_op2, exp_tag); end
      checks++; if (disp_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, disp_ready, exp_ready); end
      if (c > 0 && !rst) begin
        checks++; if (count !== 3'(exp_count)) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count, exp_count); end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    mq.delete();
    disp_alu_ctl = '0; disp_op1 = '0; disp_op2 = '0; disp_op1_rdy = 0; disp_op2_rdy = 0;
    disp_op1_tag = '0; disp_op2_tag = '0; disp_tag = '0;
    test_reset();
    test_basic();
    test_wakeup();
    test_fill();
    test_age();
    test_flush();
    test_capture();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter DEPTH, default 4, number of entries (power of two, 2..16).
REQ-002 Parameter TAG_W, default 4, width of result tags.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  squash all entries (branch mispredict).
REQ-006 disp_valid  input  1  dispatch request.
REQ-007 disp_ready  output  1  entry free; dispatch accepted when disp_valid & disp_ready.
REQ-008 disp_alu_ctl  input  alu_ctl_t  operation, passed to ALU unchanged.
REQ-009 disp_op1, disp_op2  input  32 each  operand values, valid when matching rdy bit set.
REQ-010 disp_op1_rdy, disp_op2_rdy  input  1 each  operand value present.
REQ-011 disp_op1_tag, disp_op2_tag  input  TAG_W each  producer tag when not ready.
REQ-012 disp_tag  input  TAG_W  destination tag of this instruction.
REQ-013 cdb_valid, cdb_tag, cdb_value  input  1/TAG_W/32  common data bus broadcast.
REQ-014 alu_ready  input  1  ALU accepts issue this cycle.
REQ-015 out (alu_res_stat_output_ifc.out)  output  valid, alu_ctl, op1, op2, tag to ALU.
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 Each entry holds busy, alu_ctl, op1/op2 value, op1/op2 rdy, op1/op2 tag, dest tag, age.
REQ-018 disp_ready SHALL equal (count < DEPTH) & ~flush; no same-cycle reuse of an entry issued this cycle.
REQ-019 Accepted dispatch writes the lowest-index free entry; entry busy from next cycle.
REQ-020 Dispatch-time capture: if cdb_valid and cdb_tag equals a not-ready dispatching source tag, that operand SHALL be stored ready with cdb_value.
REQ-021 Wake-up: every busy entry with a not-ready operand whose tag equals cdb_tag (cdb_valid=1) SHALL capture cdb_value and set rdy at the clock edge; both operands may match one broadcast.
REQ-022 Entry eligible when busy and both operands ready; selection is oldest-first (earliest accepted dispatch), ties impossible.
REQ-023 out.valid = 1 when any eligible entry exists, alu_ready = 1 and flush = 0; out fields driven from the selected entry combinationally.
REQ-024 Issued entry (out.valid & alu_ready) SHALL be freed at the clock edge; at most one issue per cycle.
REQ-025 out.valid = 0 implies out.op1, out.op2, out.tag driven to 0 and out.alu_ctl to ALUCTL_NOP.
REQ-026 Minimum latency dispatch-to-issue: 1 cycle (fully ready dispatch in cycle N issues in N+1).
REQ-027 flush=1: all entries cleared at the edge, dispatch that cycle dropped, no issue that cycle; count = 0 next cycle.
REQ-028 count updates: +1 on accepted dispatch, -1 on issue, unchanged when both occur in the same cycle.
REQ-029 Age ordering SHALL remain correct across arbitrary interleavings of dispatch, issue and free-slot reuse.

Reset
REQ-030 rst=1 at an edge: all entries not busy, count = 0, ages cleared; takes priority over flush, dispatch, wake-up.
REQ-031 During and after reset cycle, out.valid = 0 and disp_ready = 0 while rst asserted.

Configuration
REQ-032 Macro RS_WAKEUP_BYPASS_EN: when defined, a busy entry whose last missing operand matches the current CDB broadcast is eligible this cycle, with cdb_value forwarded onto out.op1/out.op2; oldest-first still applies.
REQ-033 Without RS_WAKEUP_BYPASS_EN, an entry becomes eligible only the cycle after its final operand is captured.

Verification
REQ-034 Reset, then dispatch ADDU op1=5 op2=7 both ready tag=3 -> next cycle out.valid=1, op1=5, op2=7, tag=3; count 1->0.
REQ-035 Dispatch op1 waiting tag=2, then cdb_valid tag=2 value=0x10 two cycles later -> issue op1=0x10 one cycle after broadcast (same cycle with RS_WAKEUP_BYPASS_EN).
REQ-036 Fill 4 entries with alu_ready=0 -> disp_ready=0, count=4; raise alu_ready -> issue in dispatch order tags 1,2,3,4.
REQ-037 Older entry waiting, younger ready -> younger issues first; when older wakes, older preferred over later-dispatched ready entries.
REQ-038 flush with 3 busy entries and concurrent dispatch -> out.valid=0 that cycle, count=0 next cycle, no later issue of squashed tags.
REQ-039 Dispatch with disp_op2_tag=5 while cdb_valid tag=5 value=0xFF -> stored ready, issues next cycle with op2=0xFF.
